// File: rtl/aes_enc_pkg.sv
// Shared types and constants for the AES-256 encryption datapath stages.
// Round-key buffer depth is one more than the round count (initial key plus one per round).
package aes_enc_pkg;

  localparam int AES_N      = 16;
  localparam int AES256_NR  = 14;
  localparam int AES_NUM_RK = AES256_NR + 1;
  localparam int AES_RW     = 4;

  typedef logic [AES_N-1:0][7:0] state_t;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } ark_fsm_t;

endpackage

// File: rtl/mod_enc_rkBuffer.sv
// Round-key register file: sequential write pointer, full flag, one combinational read port.
// Write takes effect next cycle; the caller gates wr_vld, so there is no backpressure here.
module mod_enc_rkBuffer #(
  parameter int N  = 16,
  parameter int NR = 14,
  parameter int RW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_vld,
  input  logic [N-1:0][7:0] wr_dat,
  input  logic [RW-1:0]     rd_idx,
  output logic [N-1:0][7:0] rd_dat,
  output logic              wr_last,
  output logic              full
);

  logic [N-1:0][7:0] mem [NR+1];
  logic [RW-1:0]     wr_ptr;

  assign wr_last = (wr_ptr == RW'(NR));
  assign rd_dat  = mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      full   <= 1'b0;
    end else if (wr_vld) begin
      if (wr_last) begin
        wr_ptr <= '0;
        full   <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Key storage is deliberately left unreset; contents are only trusted once full is set.
  always_ff @(posedge clk) begin
    if (wr_vld && !clear) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

endmodule

// File: rtl/mod_enc_addroundkey.sv
// AddRoundKey stage: XORs the state with the buffered key for the internally tracked round, 1-cycle latency.
// key_ready is high only while loading keys; enable is never backpressured once all keys are loaded.
module mod_enc_addroundkey
  import aes_enc_pkg::*;
#(
  parameter int N  = AES_N,
  parameter int NR = AES256_NR,
  parameter int RW = AES_RW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [N-1:0][7:0] key_in,
  input  logic              key_clear,
  input  logic              enable,
  input  logic [N-1:0][7:0] state,
  output logic [N-1:0][7:0] state_out,
  output logic              done,
  output logic [RW-1:0]     round,
  output logic              last_round,
  output logic              keys_loaded
);

  ark_fsm_t          fsm_q, fsm_d;
  logic              wr_vld;
  logic              wr_last;
  logic [N-1:0][7:0] rk;

  assign key_ready  = (fsm_q == S_LOAD);
  assign wr_vld     = key_valid && key_ready && !key_clear;
  assign last_round = (round == RW'(NR));

  mod_enc_rkBuffer #(
    .N  (N),
    .NR (NR),
    .RW (RW)
  ) u_rkbuf (
    .clk     (clk),
    .reset   (reset),
    .clear   (key_clear),
    .wr_vld  (wr_vld),
    .wr_dat  (key_in),
    .rd_idx  (round),
    .rd_dat  (rk),
    .wr_last (wr_last),
    .full    (keys_loaded)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= S_LOAD;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    if (key_clear) begin
      fsm_d = S_LOAD;
    end else if (fsm_q == S_LOAD && wr_vld && wr_last) begin
      fsm_d = S_RUN;
    end
  end

  // key_clear beats enable; state_out is left untouched by a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_out <= '0;
      done      <= 1'b0;
      round     <= '0;
    end else if (key_clear) begin
      done  <= 1'b0;
      round <= '0;
    end else if (fsm_q == S_RUN && enable) begin
      state_out <= state ^ rk;
      done      <= 1'b1;
      round     <= last_round ? '0 : round + 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_enc_addroundkey.sv
// Directed bench for mod_enc_addroundkey: scoreboard queue of expected state_out values,
// immediate-assertion checks on every observation point.
module tb_mod_enc_addroundkey;
  import aes_enc_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   key_valid;
  logic   key_ready;
  state_t key_in;
  logic   key_clear;
  logic   enable;
  state_t state;
  state_t state_out;
  logic   done;
  logic [3:0] round;
  logic   last_round;
  logic   keys_loaded;

  state_t q[$];
  state_t mk[15];
  int     rm;
  int     checks;
  int     failures;

  always #5 clk = ~clk;

  mod_enc_addroundkey dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_in      (key_in),
    .key_clear   (key_clear),
    .enable      (enable),
    .state       (state),
    .state_out   (state_out),
    .done        (done),
    .round       (round),
    .last_round  (last_round),
    .keys_loaded (keys_loaded)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set; sample 1ns after the edge and drain the scoreboard on done.
  task automatic cyc();
    state_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=done expected=no_result");
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_state_out", state_out, e);
      end
    end
  endtask

  task automatic enq(input state_t st);
    state  = st;
    enable = 1'b1;
    q.push_back(st ^ mk[rm]);
    rm = (rm == 14) ? 0 : rm + 1;
  endtask

  // c3 != 0 makes key 0 the FIPS-197 C.3 key (bytes 00..0f); other keys are r in every byte.
  task automatic load(input int c3);
    state_t kv;
    key_valid = 1'b1;
    for (int r = 0; r < 15; r++) begin
      kv = {16{8'(r)}};
      if (c3 != 0 && r == 0) begin
        for (int j = 0; j < 16; j++) kv[j] = 8'(j);
      end
      key_in = kv;
      mk[r]  = kv;
      if (r == 14) begin
        chk("ready_before_last", 128'(key_ready), 128'(1));
        chk("loaded_before_last", 128'(keys_loaded), 128'(0));
      end
      cyc();
    end
    key_valid = 1'b0;
    rm = 0;
    chk("ready_after_load", 128'(key_ready), 128'(0));
    chk("loaded_after_load", 128'(keys_loaded), 128'(1));
  endtask

  initial begin
    state_t st, so;
    checks    = 0;
    failures  = 0;
    rm        = 0;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    key_clear = 1'b0;
    enable    = 1'b0;
    state     = '0;

    // Reset
    cyc();
    cyc();
    chk("rst_state_out", state_out, '0);
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_keys_loaded", 128'(keys_loaded), 128'(0));
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    reset = 1'b1;
    enable = 1'b1;
    cyc();
    chk("load_enable_ignored", 128'(done), 128'(0));
    enable = 1'b0;

    // Load 15 keys, then a 16th that must not land in slot 0
    load(0);
    key_valid = 1'b1;
    key_in    = {16{8'hAA}};
    cyc();
    key_valid = 1'b0;
    chk("extra_key_loaded", 128'(keys_loaded), 128'(1));
    enq('0);
    cyc();
    enable = 1'b0;
    chk("k0_readback_done", 128'(done), 128'(1));
    chk("k0_round", 128'(round), 128'(rm));

    // Burst through all 15 keys
    key_clear = 1'b1;
    cyc();
    key_clear = 1'b0;
    chk("clear_key_ready", 128'(key_ready), 128'(1));
    chk("clear_round", 128'(round), 128'(0));
    load(0);
    for (int i = 0; i < 15; i++) begin
      enq('0);
      chk("burst_last_round", 128'(last_round), 128'(i == 14));
      cyc();
      chk("burst_done", 128'(done), 128'(1));
    end
    enable = 1'b0;
    chk("burst_round_wrap", 128'(round), 128'(0));
    cyc();
    chk("burst_done_drop", 128'(done), 128'(0));

    // FIPS-197 C.3 round 0
    key_clear = 1'b1;
    cyc();
    key_clear = 1'b0;
    load(1);
    for (int j = 0; j < 16; j++) st[j] = 8'(8'h11 * j);
    enq(st);
    cyc();
    enable = 1'b0;
    for (int j = 0; j < 16; j++) so[j] = 8'(8'h10 * j);
    chk("c3_state_out", state_out, so);
    chk("c3_done", 128'(done), 128'(1));
    chk("c3_round", 128'(round), 128'(1));
    cyc();
    chk("c3_done_one_cycle", 128'(done), 128'(0));

    // Reset mid-run after five more rounds
    for (int i = 0; i < 5; i++) begin
      enq({16{8'(8'h3c + i)}});
      cyc();
    end
    enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_state_out", state_out, '0);
    chk("async_done", 128'(done), 128'(0));
    chk("async_round", 128'(round), 128'(0));
    chk("async_keys_loaded", 128'(keys_loaded), 128'(0));
    #2 reset = 1'b1;
    rm = 0;
    enable = 1'b1;
    state  = {16{8'hff}};
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_no_done", 128'(done), 128'(0));
    end
    enable = 1'b0;
    load(0);

    // key_clear together with enable
    enq({16{8'h5a}});
    cyc();
    enq({16{8'ha5}});
    cyc();
    so = state_out;
    state     = {16{8'h77}};
    enable    = 1'b1;
    key_clear = 1'b1;
    cyc();
    key_clear = 1'b0;
    enable    = 1'b0;
    chk("clr_en_done", 128'(done), 128'(0));
    chk("clr_en_round", 128'(round), 128'(0));
    chk("clr_en_key_ready", 128'(key_ready), 128'(1));
    chk("clr_en_state_out", state_out, so);
    chk("clr_en_keys_loaded", 128'(keys_loaded), 128'(0));

    chk("sb_empty", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_enc_addroundkey.md
Name: mod_enc_addRoundKey

Overview:
Encryption-datapath stage directly downstream of mod_enc_mixColumns. It XORs the 16-byte state with the current AES-256 round key. It holds a 15-entry round-key buffer filled from key expansion over a valid/ready handshake. It tracks the round index internally, so the round controller only supplies enable and state.

Parameters:
N, 16, bytes per state/round key
NR, 14, AES-256 round count; buffer depth NR+1 = 15
RW, 4, width of round index

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
key_valid  input  1  round key present on key_in
key_ready  output  1  buffer accepting keys
key_in  input  [N-1:0][7:0]  round key; key_in[j] aligns with state[j]
key_clear  input  1  synchronous flush of buffer and round index
enable  input  1  apply current round key to state
state  input  [N-1:0][7:0]  state from mod_enc_mixColumns
state_out  output  [N-1:0][7:0]  registered state XOR round key
done  output  1  state_out valid, one cycle per accepted enable
round  output  RW  index of next round key to be applied (0..14)
last_round  output  1  round == NR (combinational)
keys_loaded  output  1  all 15 keys stored

Behaviour:
- Reset (reset=0, async): state_out=0, done=0, round=0, wr_ptr=0, keys_loaded=0, FSM=S_LOAD. Key storage itself is not reset and is unusable until reloaded.
- FSM states: S_LOAD, S_RUN.
- S_LOAD:
  - key_ready=1.
  - A key is accepted on any edge with key_valid && key_ready: keybuf[wr_ptr] <= key_in, wr_ptr++.
  - On the 15th accept (wr_ptr==14): keys_loaded<=1 and FSM -> S_RUN.
  - enable is ignored in S_LOAD; done stays 0 and state_out holds.
- S_RUN:
  - key_ready=0; key_valid is ignored.
  - When enable=1 at an edge: state_out <= state ^ keybuf[round] (bytewise, per index j), done<=1, round <= (round==NR) ? 0 : round+1.
  - When enable=0: done<=0; state_out and round hold.
- Latency is 1 cycle. Throughput is 1 state/cycle: enable held high gives back-to-back results with done continuously high.
- last_round=1 while round==14, i.e. the next enable applies the final key. After that enable, round wraps to 0 for the next block.
- key_clear (synchronous, any state) returns to S_LOAD with wr_ptr=0, round=0, keys_loaded=0, done=0; state_out holds. key_clear has priority over enable and key_valid in the same cycle, and no key is written that cycle.
- Reset asserted mid-operation aborts immediately to reset values. Partial key loads are discarded.
- There is no arithmetic beyond the XOR. The round index never exceeds NR.

Decomposition:
- Shared package aes_enc_pkg:
  - typedef state_t = logic [N-1:0][7:0]
  - localparams AES256_NR=14, AES_NUM_RK=15, AES_N=16
  - FSM enum {S_LOAD, S_RUN}
- One sub-module, mod_enc_rkBuffer:
  - 15x128-bit register file with write pointer, full flag and one combinational read port indexed by round.
  - Instantiated once; the top level holds the FSM, round counter and output register.

Test Plan:
1. Reset: drive reset=0 for 2 cycles, then release -> state_out=0, done=0, round=0, keys_loaded=0, key_ready=1.
2. Load: key_valid held high with K[r][j]=r (r=0..14) -> key_ready drops and keys_loaded=1 the cycle after the 15th accept. A 16th key (all 8'hAA) is ignored: keybuf[0] is still all 8'h00 when read back via enable with state=0.
3. FIPS-197 C.3 round 0:
   - Stimulus: K[0][j]=j (8'h00..8'h0f); state[j]=8'h11*j (8'h00,8'h11,..,8'hff); single-cycle enable.
   - Response: the next cycle gives state_out[j]=8'h10*j (8'h00,8'h10,..,8'hf0), done=1 for exactly 1 cycle, round=1.
4. Burst: keys from scenario 2, state=0, enable high 15 cycles -> state_out sequence K[0]..K[14] (bytes 8'h00..8'h0e), done high 15 cycles. last_round=1 during the 15th enable cycle; round=0 afterwards.
5. Reset mid-run: after 5 enabled rounds, pulse reset=0 -> state_out=0, done=0, round=0, keys_loaded=0 asynchronously. A following enable produces no done until 15 keys are reloaded.
6. Simultaneous: in S_RUN assert key_clear and enable together -> done stays 0, round=0, key_ready=1 next cycle, state_out unchanged.
